mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Single-port SRAM arbiter and access sequencer shared by the instruction-fetch stage and the MEM stage of the 16-bit pipeline. It grants one requester at a time and drives the CE/OE/WE strobe sequence for multi-cycle reads and writes. It returns read data with a one-cycle acknowledge and raises a stall to the hazard unit while any request is outstanding. The MEM port is fed directly by the EX/MEM pipeline register outputs (memread, memwrite, alures as address, memdata as write data).

## Interface
- ADDR_W, 18, SRAM address width; the 16-bit request address is zero-extended to ADDR_W.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  instruction fetch request; held until if_ack_o.
- if_addr_i  in  16  fetch address.
- if_data_o  out  16  fetched word; valid in the if_ack_o cycle and held until the next IF read completes.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- mem_read_i  in  1  MEM-stage load request.
- mem_write_i  in  1  MEM-stage store request. If both mem_read_i and mem_write_i are asserted, the request is treated as a write.
- mem_addr_i  in  16  load/store address.
- mem_wdata_i  in  16  store data.
- mem_rdata_o  out  16  load data; valid in the mem_ack_o cycle and held until the next MEM read completes.
- mem_ack_o  out  1  one-cycle completion pulse for MEM.
- stall_o  out  1  combinational; high while a request is present and its ack is not asserted in the current cycle.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_data_io  inout  16  SRAM data bus; high-Z except in write states.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - Evaluates the pending requests.
  - Latches the winner, its address and its write data into internal registers.
  - Later changes to the inputs during an access are ignored.
- Default priority: MEM beats IF, because the MEM instruction is older. IF is granted only when there is no MEM request.
- Read path:
  - IDLE → RD_SETUP: address is driven; CE=0, OE=0.
  - RD_SETUP → RD_SAMPLE: sram_data_io is captured into the granted port's data register at the end of RD_SAMPLE.
  - The ack pulses in the cycle after RD_SAMPLE, with the FSM back in IDLE.
- Write path:
  - WR_SETUP: address and data are driven; CE=0, WE=1.
  - WR_PULSE: WE=0.
  - WR_HOLD: WE=1; data is still driven.
  - Then IDLE, with mem_ack_o pulsing.
- The IF port never writes.
- In IDLE, strobes are all 1, the bus is high-Z, and sram_addr_o holds its last value.
- Ack cycle: the FSM is in IDLE and may grant a new request in that same cycle. A requester that still holds its request after its ack is treated as issuing a new request.
- A request withdrawn mid-access has no effect: the access completes and the ack is still issued.

## Timing
- Read latency: request seen in IDLE at edge N → ack high during cycle N+3. A back-to-back read completes every 3 cycles.
- Write latency: request seen at edge N → mem_ack_o high during cycle N+4.
- stall_o is high in the request cycle and low in the ack cycle. The pipeline advances on the ack edge.
- Reset values:
  - FSM = IDLE.
  - All strobes = 1; sram_data_io = Z; sram_addr_o = 0.
  - if_data_o = 0, mem_rdata_o = 0.
  - Acks = 0; internal grant/last-grant = IF.
- Reset mid-access aborts immediately and asynchronously. WE/OE/CE go to 1 without waiting for a clock, and no ack is issued.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_grant register is updated on each grant.
  - When both ports request, the port not granted last wins.
  - A single requester always wins.
- ARB_RR_EN undefined: fixed MEM-over-IF priority; no last_grant register.

## Test plan
- Reset, then IF read of 0x0010 with SRAM model holding 0x1234 → if_ack_o pulses 3 cycles after the request; if_data_o = 0x1234; stall_o low in the ack cycle.
- MEM write 0xBEEF to 0x0200 → exactly one WE low cycle; bus driven only in WR_*; mem_ack_o at cycle +4. A following MEM read of 0x0200 returns 0xBEEF.
- IF and MEM requests asserted together (read 0x0040 / read 0x0300):
  - Fixed priority: MEM acks first, IF acks 3 cycles later.
  - With ARB_RR_EN and last_grant = MEM: IF acks first.
- mem_read_i and mem_write_i both high at 0x0005 → write sequence is performed and no read capture occurs. mem_addr_i changed mid-access → SRAM still sees the latched 0x0005.
- RST pulled low during WR_PULSE → sram_we_n_o = 1 asynchronously; no mem_ack_o. After release, FSM is in IDLE and the next request is served normally.
- Continuous IF requests for 4 fetches → acks every 3 cycles; stall_o low only in ack cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Single-port SRAM arbiter and access sequencer shared by the instruction
//   fetch (IF) port and the MEM-stage port of the 16-bit pipeline.
//   The module grants one requester at a time. It then sequences the CE/OE/WE
//   strobes for a 2-cycle read or a 3-cycle write. A one-cycle acknowledge is
//   returned in the IDLE cycle that follows each access.
//
//   Build option:
//     ARB_RR_EN  defined   -> round-robin between IF and MEM (1-bit last grant)
//                undefined -> fixed priority, MEM over IF
//
//   Ports:
//     CLK, RST              clock / asynchronous active-low reset
//     if_req_i, if_addr_i   fetch request and address
//     if_data_o, if_ack_o   fetched word (held) and completion pulse
//     mem_read_i/_write_i   load / store request (both high -> store)
//     mem_addr_i, mem_wdata_i
//     mem_rdata_o, mem_ack_o  load data (held) and completion pulse
//     stall_o               request present and not acknowledged this cycle
//     sram_addr_o           SRAM address, zero-extended request address
//     sram_data_io          SRAM data bus, driven only in write states
//     sram_ce_n_o/oe_n_o/we_n_o  active-low SRAM strobes
module mem_bus_arbiter #(
    parameter int ADDR_W = 18
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req_i,
    input  logic [15:0]       if_addr_i,
    output logic [15:0]       if_data_o,
    output logic              if_ack_o,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [15:0]       mem_addr_i,
    input  logic [15:0]       mem_wdata_i,
    output logic [15:0]       mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  logic [15:0]       sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_SAMPLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_grant;      // 0 = IF, 1 = MEM
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_if_data;
    logic [15:0]        r_mem_data;
    logic               r_if_ack;
    logic               r_mem_ack;

    logic               w_mem_req;
    logic               w_any_req;
    logic               w_grant_mem;
    logic               w_is_write;
    logic               w_drive;

    assign w_mem_req = mem_read_i | mem_write_i;
    assign w_any_req = w_mem_req | if_req_i;

`ifdef ARB_RR_EN
    logic r_last_grant;  // 0 = IF, 1 = MEM

    // On contention the port that did not win last time gets the grant.
    assign w_grant_mem = w_mem_req & (~if_req_i | ~r_last_grant);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_grant <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = w_mem_req;
`endif

    // A store wins over a load when both strobes are high. IF only reads.
    assign w_is_write = w_grant_mem & mem_write_i;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_is_write ? S_WR_SETUP : S_RD_SETUP;
                end
            end
            S_RD_SETUP:  w_next = S_RD_SAMPLE;
            S_RD_SAMPLE: w_next = S_IDLE;
            S_WR_SETUP:  w_next = S_WR_PULSE;
            S_WR_PULSE:  w_next = S_WR_HOLD;
            S_WR_HOLD:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode. Strobes come straight from the state, so an asynchronous
    // reset releases them without waiting for a clock edge.
    always_comb begin
        sram_ce_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        w_drive     = 1'b0;
        case (r_state)
            S_RD_SETUP, S_RD_SAMPLE: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                sram_ce_n_o = 1'b0;
                w_drive     = 1'b1;
            end
            S_WR_PULSE: begin
                sram_ce_n_o = 1'b0;
                sram_we_n_o = 1'b0;
                w_drive     = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch, read capture and ack generation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_grant    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_data  <= '0;
            r_mem_data <= '0;
            r_if_ack   <= 1'b0;
            r_mem_ack  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_grant <= w_grant_mem;
                r_addr  <= ADDR_W'(w_grant_mem ? mem_addr_i : if_addr_i);
                r_wdata <= mem_wdata_i;
            end
            if (r_state == S_RD_SAMPLE) begin
                if (r_grant) begin
                    r_mem_data <= sram_data_io;
                end else begin
                    r_if_data <= sram_data_io;
                end
            end
            r_if_ack  <= (r_state == S_RD_SAMPLE) && !r_grant;
            r_mem_ack <= ((r_state == S_RD_SAMPLE) && r_grant) ||
                         (r_state == S_WR_HOLD);
        end
    end

    assign sram_data_io = w_drive ? r_wdata : 'z;
    assign sram_addr_o  = r_addr;
    assign if_data_o    = r_if_data;
    assign mem_rdata_o  = r_mem_data;
    assign if_ack_o     = r_if_ack;
    assign mem_ack_o    = r_mem_ack;
    assign stall_o      = (if_req_i & ~r_if_ack) | (w_mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a behavioural SRAM model and
// per-port scoreboards. Each scoreboard entry is the data value that port
// must show in its ack cycle.
module tb_mem_bus_arbiter;

    logic        CLK;
    logic        RST;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_data;
    logic        if_ack;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;

    mem_bus_arbiter #(.ADDR_W(18)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_data_o    (if_data),
        .if_ack_o     (if_ack),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_rdata_o  (mem_rdata),
        .mem_ack_o    (mem_ack),
        .stall_o      (stall),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data),
        .sram_ce_n_o  (ce_n),
        .sram_oe_n_o  (oe_n),
        .sram_we_n_o  (we_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // SRAM model: reads while CE and OE are low, writes on the rising edge of WE.
    logic [15:0] sram [0:1023];
    assign sram_data = (!ce_n && !oe_n) ? sram[sram_addr[9:0]] : 'z;

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        sram[10'h010] = 16'h1234;
        sram[10'h011] = 16'h1111;
        sram[10'h012] = 16'h2222;
        sram[10'h013] = 16'h3333;
        sram[10'h040] = 16'h4040;
        sram[10'h300] = 16'h3003;
        forever begin
            @(posedge we_n);
            if (!ce_n) sram[sram_addr[9:0]] = sram_data;
        end
    end

    logic [15:0] if_q [$];
    logic [15:0] mem_q [$];
    int          mem_ack_cnt = 0;
    int          we_low      = 0;
    int          bad_drive   = 0;

    // Scoreboard pop on every ack, and bus-ownership monitors.
    always @(negedge CLK) begin
        if (if_ack) begin
            check("if_q_nonempty", 32'(if_q.size() != 0), 1);
            if (if_q.size() != 0) check("if_data", 32'(if_data), 32'(if_q.pop_front()));
        end
        if (mem_ack) begin
            mem_ack_cnt++;
            check("mem_q_nonempty", 32'(mem_q.size() != 0), 1);
            if (mem_q.size() != 0) check("mem_rdata", 32'(mem_rdata), 32'(mem_q.pop_front()));
        end
        if (!we_n) we_low++;
        if (ce_n && sram_data !== 16'hzzzz) bad_drive++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_ack(input bit is_mem, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            cyc = k;
            if (is_mem ? mem_ack : if_ack) break;
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] last_mem_rd;
    logic [15:0] fetch_val [0:3];
    int cyc, we0, ack0, if_at, mem_at;

    initial begin
        fetch_val[0] = 16'h1234; fetch_val[1] = 16'h1111;
        fetch_val[2] = 16'h2222; fetch_val[3] = 16'h3333;
        RST = 1'b0; if_req = 0; if_addr = '0; mem_read = 0; mem_write = 0;
        mem_addr = '0; mem_wdata = '0; last_mem_rd = '0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_ce", 32'(ce_n), 1);
        check("rst_oe", 32'(oe_n), 1);
        check("rst_we", 32'(we_n), 1);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_bus_z", 32'(sram_data === 16'hzzzz), 1);
        check("rst_if_data", 32'(if_data), 0);
        check("rst_acks", 32'({if_ack, mem_ack}), 0);
        RST = 1'b1;

        // IF read of 0x0010
        next_cycle();
        if_req = 1; if_addr = 16'h0010; if_q.push_back(16'h1234);
        @(negedge CLK);
        check("t1_stall_req", 32'(stall), 1);
        wait_ack(0, cyc);
        check("t1_latency", cyc, 3);
        check("t1_stall_ack", 32'(stall), 0);
        if_req = 0;

        // MEM write 0xBEEF to 0x0200, then read it back
        next_cycle();
        we0 = we_low;
        mem_write = 1; mem_addr = 16'h0200; mem_wdata = 16'hBEEF;
        mem_q.push_back(last_mem_rd);
        @(negedge CLK);
        wait_ack(1, cyc);
        check("t2_wr_latency", cyc, 4);
        check("t2_we_pulses", we_low - we0, 1);
        check("t2_sram_content", 32'(sram[10'h200]), 32'hBEEF);
        mem_write = 0;
        next_cycle();
        mem_read = 1; mem_q.push_back(16'hBEEF); last_mem_rd = 16'hBEEF;
        @(negedge CLK);
        wait_ack(1, cyc);
        check("t2_rd_latency", cyc, 3);
        mem_read = 0;

        // Simultaneous IF read 0x0040 and MEM read 0x0300
        next_cycle();
        if_req = 1; if_addr = 16'h0040; if_q.push_back(16'h4040);
        mem_read = 1; mem_addr = 16'h0300; mem_q.push_back(16'h3003);
        last_mem_rd = 16'h3003;
        if_at = 0; mem_at = 0;
        @(negedge CLK);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (mem_ack) begin mem_at = k; mem_read = 0; end
            if (if_ack)  begin if_at = k;  if_req = 0;  end
            if (if_at != 0 && mem_at != 0) break;
        end
`ifdef ARB_RR_EN
        check("t3_if_ack_cycle", if_at, 3);
        check("t3_mem_ack_cycle", mem_at, 6);
`else
        check("t3_mem_ack_cycle", mem_at, 3);
        check("t3_if_ack_cycle", if_at, 6);
`endif

        // Read+write together is a write; address change mid-access ignored
        next_cycle();
        we0 = we_low;
        mem_read = 1; mem_write = 1; mem_addr = 16'h0005; mem_wdata = 16'h5A5A;
        mem_q.push_back(last_mem_rd);
        @(negedge CLK);
        next_cycle();
        mem_addr = 16'h0123; mem_wdata = 16'h0000;
        wait_ack(1, cyc);
        check("t4_latency", cyc, 4);
        check("t4_we_pulses", we_low - we0, 1);
        check("t4_sram_latched_addr", 32'(sram[10'h005]), 32'h5A5A);
        check("t4_sram_other_addr", 32'(sram[10'h123]), 0);
        mem_read = 0; mem_write = 0;

        // Reset during WR_PULSE
        next_cycle();
        mem_write = 1; mem_addr = 16'h0006; mem_wdata = 16'h7777;
        repeat (3) @(negedge CLK);
        check("t5_we_low_in_pulse", 32'(we_n), 0);
        ack0 = mem_ack_cnt;
        #1 RST = 1'b0;
        #1;
        check("t5_async_we", 32'(we_n), 1);
        check("t5_async_ce", 32'(ce_n), 1);
        mem_write = 0;
        @(negedge CLK);
        check("t5_rst_addr", 32'(sram_addr), 0);
        check("t5_rst_rdata", 32'(mem_rdata), 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("t5_no_ack", mem_ack_cnt - ack0, 0);
        next_cycle();
        mem_read = 1; mem_addr = 16'h0200; mem_q.push_back(16'hBEEF);
        @(negedge CLK);
        wait_ack(1, cyc);
        check("t5_post_rst_latency", cyc, 3);
        mem_read = 0;

        // Four back-to-back fetches
        next_cycle();
        if_req = 1; if_addr = 16'h0010; if_q.push_back(fetch_val[0]);
        @(negedge CLK);
        check("t6_stall_req", 32'(stall), 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            check("t6_ack_pattern", 32'(if_ack), 32'(k % 3 == 0));
            check("t6_stall_pattern", 32'(stall), 32'(k % 3 != 0));
            if (if_ack && k < 12) begin
                if_addr = 16'h0010 + 16'(k / 3);
                if_q.push_back(fetch_val[k / 3]);
            end
        end
        if_req = 0;
        repeat (4) @(negedge CLK);

        check("bus_driven_outside_write", bad_drive, 0);
        check("if_q_drained", if_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
